// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per en_fetch request over a ready handshake.
// Latency: inst_valid pulses k+1 cycles after en_fetch when imem_ready is seen k cycles after it (2 for zero-wait memory).
// Backpressure: one fetch in flight; en_fetch outside IDLE is dropped; a stalled request times out after TIMEOUT cycles.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   en_fetch                 fetch request at the current (or just-committed) PC
//   pc_we, PCSel, alu_result PC commit: next PC = PCSel ? alu_result : pc+4
//   imem_req/addr/ready/rdata  instruction-memory request/response handshake
//   instruction, inst_valid  latched word for control/decode and its update strobe
//   pc, pc_plus4             current PC and pc+4 (combinational)
//   busy, fetch_fault        request outstanding; sticky misalign/timeout flag
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_fetch,
  input  logic        pc_we,
  input  logic        PCSel,
  input  logic [31:0] alu_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        busy,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [31:0] next_pc;
  logic [31:0] fetch_addr;

  assign pc_plus4 = pc + 32'd4;
  assign next_pc  = PCSel ? alu_result : pc_plus4;
  // A commit in the same cycle as en_fetch takes effect first, so fetch from the new PC.
  assign fetch_addr = pc_we ? next_pc : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= NOP_WORD;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      inst_valid  <= 1'b0;
      busy        <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= 16'd0;
    end else begin
      if (pc_we) begin
        pc <= next_pc;
      end
      inst_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (en_fetch) begin
            if (fetch_addr[1:0] != 2'b00) begin
              // Misaligned target: never touch memory, hand control a NOP.
              state       <= FAULT;
              fetch_fault <= 1'b1;
              instruction <= NOP_WORD;
              inst_valid  <= 1'b1;
            end else begin
              state       <= REQ;
              imem_addr   <= fetch_addr;
              imem_req    <= 1'b1;
              busy        <= 1'b1;
              wait_cnt    <= 16'd0;
              fetch_fault <= 1'b0;
            end
          end
        end

        REQ: begin
          if (imem_ready) begin
            state       <= DONE;
            instruction <= imem_rdata;
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            inst_valid  <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= FAULT;
            instruction <= NOP_WORD;
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            fetch_fault <= 1'b1;
            inst_valid  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: table of fetch transactions with a scoreboard queue,
// a wait-state memory model, and hand sequences for reset, idle-ready and mid-request reset.
// Expected values are written out per transaction from the behaviour of the block.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_fetch = 1'b0;
  logic        pc_we = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        busy;
  logic        fetch_fault;

  inst_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16),
    .NOP_WORD(32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_fetch   (en_fetch),
    .pc_we      (pc_we),
    .PCSel      (PCSel),
    .alu_result (alu_result),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_valid (inst_valid),
    .busy       (busy),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // commit: 0 none, 1 pc_we in the cycle before en_fetch, 2 pc_we together with en_fetch
  typedef struct {
    logic [1:0]  commit;
    logic        pcsel;
    logic [31:0] alu;
    int          wait_cyc;   // -1: memory never answers
    logic        poke;       // extra en_fetch while the request is outstanding
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic        exp_fault;
    int          exp_reqs;   // cycles with imem_req high
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        fault;
    int          reqs;
  } exp_t;

  exp_t q[$];
  vec_t vecs[10];

  // Memory model: answers after mem_wait REQ cycles; idle_ready drives ready outside requests.
  int          mem_wait = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_data = 32'd0;
  logic        idle_ready = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (mem_wait >= 0 && mem_cnt == mem_wait) begin
          imem_ready = 1'b1;
          imem_rdata = mem_data;
        end else begin
          imem_ready = 1'b0;
          imem_rdata = 32'hBAD0_BAD0;
        end
        mem_cnt++;
      end else begin
        imem_ready = idle_ready;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt = 0;
      end
    end
  end

  // Monitor: checks the address during requests and pops the scoreboard on inst_valid.
  int req_cycles = 0;
  int valid_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req) begin
        req_cycles++;
        check("busy_in_req", {31'd0, busy}, 32'd1);
        if (q.size() != 0) check("imem_addr", imem_addr, q[0].addr);
      end
      if (!rst && inst_valid) begin
        exp_t e;
        valid_pulses++;
        if (q.size() == 0) begin
          check("spurious_inst_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("instruction", instruction, e.inst);
          check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
          check("req_cycles", 32'(req_cycles), 32'(e.reqs));
        end
        req_cycles = 0;
      end
    end
  end

  initial begin
    exp_t e;
    int   pulses_before;
    logic [31:0] last_inst;

    //            commit pcsel alu           wait poke rdata          exp_pc        exp_addr      exp_inst      flt reqs
    vecs[0] = '{2'd0, 1'b0, 32'h0,        0,  1'b0, 32'h0050_0093, 32'h0,        32'h0,        32'h0050_0093, 1'b0, 1};
    vecs[1] = '{2'd1, 1'b1, 32'h8,        0,  1'b0, 32'h1111_1111, 32'h8,        32'h8,        32'h1111_1111, 1'b0, 1};
    vecs[2] = '{2'd1, 1'b0, 32'h0,        0,  1'b0, 32'h2222_2222, 32'hC,        32'hC,        32'h2222_2222, 1'b0, 1};
    vecs[3] = '{2'd2, 1'b1, 32'h100,      3,  1'b1, 32'h3333_3333, 32'h100,      32'h100,      32'h3333_3333, 1'b0, 4};
    vecs[4] = '{2'd1, 1'b1, 32'h102,      0,  1'b0, 32'h0BAD_0BAD, 32'h102,      32'h0,        32'h0000_0013, 1'b1, 0};
    vecs[5] = '{2'd1, 1'b1, 32'h200,      -1, 1'b0, 32'h0BAD_0BAD, 32'h200,      32'h200,      32'h0000_0013, 1'b1, 16};
    vecs[6] = '{2'd0, 1'b0, 32'h0,        1,  1'b0, 32'h4444_4444, 32'h200,      32'h200,      32'h4444_4444, 1'b0, 2};
    vecs[7] = '{2'd1, 1'b1, 32'hFFFF_FFFC, 0, 1'b0, 32'h5555_5555, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h5555_5555, 1'b0, 1};
    vecs[8] = '{2'd1, 1'b0, 32'h0,        0,  1'b0, 32'h6666_6666, 32'h0,        32'h0,        32'h6666_6666, 1'b0, 1};
    vecs[9] = '{2'd2, 1'b0, 32'h0,        2,  1'b0, 32'h7777_7777, 32'h4,        32'h4,        32'h7777_7777, 1'b0, 3};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_instruction", instruction, 32'h0000_0013);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      mem_wait = vecs[v].wait_cyc;
      mem_data = vecs[v].rdata;
      if (vecs[v].commit == 2'd1) begin
        pc_we = 1'b1; PCSel = vecs[v].pcsel; alu_result = vecs[v].alu;
        @(posedge clk); #1;
        pc_we = 1'b0;
      end
      e.addr = vecs[v].exp_addr; e.inst = vecs[v].exp_inst;
      e.fault = vecs[v].exp_fault; e.reqs = vecs[v].exp_reqs;
      q.push_back(e);
      en_fetch = 1'b1;
      if (vecs[v].commit == 2'd2) begin
        pc_we = 1'b1; PCSel = vecs[v].pcsel; alu_result = vecs[v].alu;
      end
      @(posedge clk); #1;
      en_fetch = 1'b0; pc_we = 1'b0;
      if (vecs[v].poke) begin
        en_fetch = 1'b1;
        @(posedge clk); #1;
        en_fetch = 1'b0;
      end
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      check("drain", 32'(q.size()), 32'd0);
      q.delete();
      @(negedge clk);
      check("pc_after", pc, vecs[v].exp_pc);
      check("fault_held", {31'd0, fetch_fault}, {31'd0, vecs[v].exp_fault});
      check("idle_after", {31'd0, busy}, 32'd0);
    end

    // imem_ready outside a request must not disturb the latched word.
    last_inst = instruction;
    pulses_before = valid_pulses;
    @(posedge clk); #1;
    idle_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 idle_ready = 1'b0;
    @(negedge clk);
    check("idle_ready_inst", instruction, last_inst);
    check("idle_ready_pulses", 32'(valid_pulses), 32'(pulses_before));

    // Reset in the middle of a request takes effect before the next clock edge.
    @(posedge clk); #1;
    mem_wait = -1;
    en_fetch = 1'b1;
    @(posedge clk); #1;
    en_fetch = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("mid_req_before_rst", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_inst", instruction, 32'h0000_0013);
    @(negedge clk);
    req_cycles = 0;
    rst = 1'b0;
    mem_wait = 0;
    repeat (3) @(negedge clk);
    check("post_rst_req", {31'd0, imem_req}, 32'd0);
    check("post_rst_valid_pulses", 32'(valid_pulses), 32'(pulses_before));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch stage of the multi-cycle RISC-V core. It sits directly upstream of the control/decode block. It owns the program counter and issues requests to instruction memory through a ready handshake. It holds the fetched word stable on `instruction` for the control block's state machine, which drives `en_fetch`, `pc_we` and `PCSel` back into this block.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles to wait for imem_ready before fault (1..65535)
NOP_WORD, 32'h0000_0013, word presented on `instruction` at reset and on fault (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
en_fetch  in  1  control requests a fetch at the current PC (1-cycle pulse)
pc_we  in  1  control commits next PC (end of instruction)
PCSel  in  1  0: next PC = pc+4; 1: next PC = alu_result
alu_result  in  32  branch/jump target from ALU
imem_req  out  1  memory request valid
imem_addr  out  32  memory word address (byte address, 4-aligned)
imem_ready  in  1  memory response valid; imem_rdata valid in same cycle
imem_rdata  in  32  fetched instruction word
instruction  out  32  latched instruction to control/decode
pc  out  32  current PC
pc_plus4  out  32  pc+4, combinational, for JAL/JALR writeback
inst_valid  out  1  1-cycle pulse: instruction updated
busy  out  1  fetch in progress (state REQ)
fetch_fault  out  1  sticky fault flag: misaligned target or timeout

Behaviour:
- Reset (async, any state): pc=RESET_PC, instruction=NOP_WORD, imem_req=0, imem_addr=RESET_PC, inst_valid=0, busy=0, fetch_fault=0, timeout counter=0, state=IDLE.
- PC update on a clk edge with pc_we=1: pc <= PCSel ? alu_result : pc+4. Arithmetic is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. pc_we is honoured in every state. The issued imem_addr stays frozen until the in-flight fetch completes.
- States: IDLE, REQ, DONE, FAULT.
- IDLE: on en_fetch=1, the fetch address A is computed first:
  - A = pc if pc_we=0.
  - A = the next-PC value if pc_we=1 in the same cycle (the commit applies first).
  - If A[1:0]!=0: go to FAULT with no memory request; fetch_fault<=1; instruction<=NOP_WORD.
  - Otherwise: imem_addr<=A, imem_req<=1, counter cleared, fetch_fault<=0, go to REQ.
- REQ: imem_req=1 and imem_addr stable; busy=1.
  - If imem_ready=1: instruction<=imem_rdata, imem_req<=0, go to DONE.
  - Else the counter increments. When the counter reaches TIMEOUT-1 without ready: imem_req<=0, instruction<=NOP_WORD, fetch_fault<=1, go to FAULT.
  - en_fetch in REQ is ignored (no queueing).
- DONE: inst_valid=1 for exactly this cycle; return to IDLE next cycle. en_fetch in DONE is ignored.
- FAULT: inst_valid=1 for one cycle (control consumes the NOP); return to IDLE. fetch_fault stays 1 until the next accepted en_fetch.
- Fetch latency: en_fetch at cycle 0, ready seen at cycle k≥1 → instruction updated and inst_valid=1 at cycle k+1. With zero-wait memory (ready in the first REQ cycle), inst_valid rises 2 cycles after en_fetch.
- imem_ready while not in REQ is ignored; instruction is unchanged.
- instruction holds its value between fetches. It changes only on a DONE or FAULT entry, or on reset.
- Reset asserted mid-REQ: imem_req drops immediately (async); no capture occurs.

Test Plan:
- Reset then en_fetch with RESET_PC=0 and zero-wait memory returning 32'h00500093 → imem_addr=0, imem_req high 1 cycle, instruction=32'h00500093, inst_valid pulse 2 cycles after en_fetch.
- pc_we=1, PCSel=0 at pc=0x8, then en_fetch → pc=0xC, imem_addr=0xC. Repeat with pc_we and en_fetch in the same cycle, PCSel=1, alu_result=0x100 → imem_addr=0x100.
- Memory with 3-cycle wait: imem_addr held stable 3 cycles; a second en_fetch mid-wait is ignored; exactly one inst_valid pulse.
- Misaligned branch: PCSel=1, alu_result=0x102, pc_we, then en_fetch → imem_req never asserted, fetch_fault=1, instruction=32'h00000013, inst_valid pulse.
- Timeout: TIMEOUT=16, imem_ready held 0 → imem_req drops after 16 REQ cycles, fetch_fault=1. The next en_fetch at an aligned address clears fetch_fault.
- Wrap and reset: pc=0xFFFFFFFC, pc_we with PCSel=0 → pc=0. Separately, assert rst during REQ → imem_req=0 and pc=RESET_PC combinationally, before the next clock edge.
